// File: rtl/bp_be_fwd_pipe.sv
// Result-tracking pipe: per-stage rd writes for the bypass network,
// RAW hazard flags on unproduced results, and register-file writeback.
package bp_be_fwd_pkg;
    typedef enum logic [0:0] {e_bp_default_cfg} bp_params_e;

    function automatic int reg_addr_width(bp_params_e cfg);
        unique case (cfg)
            e_bp_default_cfg: return 5;
            default:          return 5;
        endcase
    endfunction

    function automatic int dpath_width(bp_params_e cfg);
        unique case (cfg)
            e_bp_default_cfg: return 64;
            default:          return 64;
        endcase
    endfunction
endpackage

module bp_be_fwd_pipe
    import bp_be_fwd_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int depth_p = 4,
    parameter int els_p = 2,
    localparam int reg_addr_width_p = reg_addr_width(bp_params_p),
    localparam int dpath_width_p = dpath_width(bp_params_p)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 iss_v_i,
    input  logic                                 iss_rd_w_v_i,
    input  logic [reg_addr_width_p-1:0]          iss_rd_addr_i,
    input  logic [depth_p-1:0]                   res_v_i,
    input  logic [depth_p*dpath_width_p-1:0]     res_data_i,
    input  logic [depth_p-1:0]                   kill_i,
    input  logic [els_p*reg_addr_width_p-1:0]    chk_addr_i,
    output logic [els_p-1:0]                     hazard_o,
    output logic [depth_p-1:0]                   fwd_rd_v_o,
    output logic [depth_p*reg_addr_width_p-1:0]  fwd_rd_addr_o,
    output logic [depth_p*dpath_width_p-1:0]     fwd_rd_o,
    output logic                                 wb_v_o,
    output logic [reg_addr_width_p-1:0]          wb_addr_o,
    output logic [dpath_width_p-1:0]             wb_data_o,
    output logic                                 error_o
);
    localparam int L = depth_p - 1;
    localparam int AW = reg_addr_width_p;
    localparam int DW = dpath_width_p;

    logic [depth_p-1:0] v_q, w_q, dv_q;
    logic [AW-1:0]      addr_q [depth_p];
    logic [DW-1:0]      data_q [depth_p];
    logic               err_q;

    logic [depth_p-1:0] pend;
    logic [L-1:0]       cap;
    logic               err_now;

    assign pend = v_q & w_q & ~dv_q;
    // Kill wins over a same-cycle result; first result wins over later ones.
    assign cap  = res_v_i[L-1:0] & pend[L-1:0] & ~kill_i[L-1:0];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q   <= '0;
            w_q   <= '0;
            dv_q  <= '0;
            err_q <= 1'b0;
            for (int k = 0; k < depth_p; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
            end
        end else begin
            v_q[0]    <= iss_v_i;
            w_q[0]    <= iss_v_i & iss_rd_w_v_i & (iss_rd_addr_i != '0);
            addr_q[0] <= iss_rd_addr_i;
            dv_q[0]   <= 1'b0;
            data_q[0] <= '0;
            for (int k = 0; k < L; k++) begin
                v_q[k+1]    <= v_q[k] & ~kill_i[k];
                w_q[k+1]    <= w_q[k];
                addr_q[k+1] <= addr_q[k];
                dv_q[k+1]   <= dv_q[k] | cap[k];
                data_q[k+1] <= cap[k] ? res_data_i[k*DW +: DW] : data_q[k];
            end
            if (err_now) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        fwd_rd_v_o    = v_q & w_q & dv_q;
        fwd_rd_addr_o = '0;
        fwd_rd_o      = '0;
        for (int k = 0; k < depth_p; k++) begin
            fwd_rd_addr_o[k*AW +: AW] = addr_q[k];
            fwd_rd_o[k*DW +: DW]      = data_q[k];
        end
    end

    always_comb begin
        hazard_o = '0;
        for (int j = 0; j < els_p; j++) begin
            for (int k = 0; k < depth_p; k++) begin
                if (pend[k] && addr_q[k] == chk_addr_i[j*AW +: AW]
                    && chk_addr_i[j*AW +: AW] != '0) begin
                    hazard_o[j] = 1'b1;
                end
            end
        end
    end

    // Reset must suppress a writeback already sitting in the last stage.
    assign wb_v_o    = ~reset_i & v_q[L] & w_q[L] & ~kill_i[L]
                     & (dv_q[L] | res_v_i[L]);
    assign wb_addr_o = addr_q[L];
    assign wb_data_o = dv_q[L] ? data_q[L] : res_data_i[L*DW +: DW];

    assign err_now = ~reset_i & pend[L] & ~res_v_i[L] & ~kill_i[L];
    assign error_o = err_q | err_now;
endmodule

// File: tb/tb_bp_be_fwd_pipe.sv
// Directed bench for bp_be_fwd_pipe with a writeback scoreboard.
module tb_bp_be_fwd_pipe;
    localparam int D  = 4;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int E  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_i;
    logic              iss_v_i;
    logic              iss_rd_w_v_i;
    logic [AW-1:0]     iss_rd_addr_i;
    logic [D-1:0]      res_v_i;
    logic [D*DW-1:0]   res_data_i;
    logic [D-1:0]      kill_i;
    logic [E*AW-1:0]   chk_addr_i;
    logic [E-1:0]      hazard_o;
    logic [D-1:0]      fwd_rd_v_o;
    logic [D*AW-1:0]   fwd_rd_addr_o;
    logic [D*DW-1:0]   fwd_rd_o;
    logic              wb_v_o;
    logic [AW-1:0]     wb_addr_o;
    logic [DW-1:0]     wb_data_o;
    logic              error_o;

    bp_be_fwd_pipe dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .iss_v_i       (iss_v_i),
        .iss_rd_w_v_i  (iss_rd_w_v_i),
        .iss_rd_addr_i (iss_rd_addr_i),
        .res_v_i       (res_v_i),
        .res_data_i    (res_data_i),
        .kill_i        (kill_i),
        .chk_addr_i    (chk_addr_i),
        .hazard_o      (hazard_o),
        .fwd_rd_v_o    (fwd_rd_v_o),
        .fwd_rd_addr_o (fwd_rd_addr_o),
        .fwd_rd_o      (fwd_rd_o),
        .wb_v_o        (wb_v_o),
        .wb_addr_o     (wb_addr_o),
        .wb_data_o     (wb_data_o),
        .error_o       (error_o)
    );

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;

    wb_t sb [$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc   = 0;
    int  t;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wb_mon();
        wb_t e;
        if (wb_v_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL wb_spurious: got write addr %0d expected none",
                       wb_addr_o);
            end else begin
                e = sb.pop_front();
                chk("wb_cyc", cyc, e.due);
                chk("wb_addr", wb_addr_o, e.addr);
                chk("wb_data", wb_data_o, e.data);
            end
        end
    endtask

    task automatic step();
        #1;
        wb_mon();
        @(posedge clk);
        #1;
        cyc++;
        iss_v_i       = 1'b0;
        iss_rd_w_v_i  = 1'b0;
        iss_rd_addr_i = '0;
        res_v_i       = '0;
        res_data_i    = '0;
        kill_i        = '0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic dispatch(input logic [AW-1:0] a);
        iss_v_i       = 1'b1;
        iss_rd_w_v_i  = 1'b1;
        iss_rd_addr_i = a;
    endtask

    task automatic result(input int k, input logic [DW-1:0] d);
        res_v_i[k]            = 1'b1;
        res_data_i[k*DW +: DW] = d;
    endtask

    task automatic expect_wb(input int due, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
        wb_t e;
        e.due  = due;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i       = 1'b1;
        iss_v_i       = 1'b1;
        iss_rd_w_v_i  = 1'b1;
        iss_rd_addr_i = 5'd5;
        res_v_i       = '0;
        res_data_i    = '0;
        kill_i        = '0;
        chk_addr_i    = {5'd5, 5'd5};

        // reset held two cycles with dispatch asserted
        step();
        reset_i = 1'b1;
        dispatch(5'd5);
        step();
        reset_i = 1'b0;
        settle();
        chk("rst_fwd_v", fwd_rd_v_o, '0);
        chk("rst_fwd_addr", fwd_rd_addr_o, '0);
        chk("rst_fwd_data", fwd_rd_o[DW-1:0], '0);
        chk("rst_hazard", hazard_o, '0);
        chk("rst_wb_v", wb_v_o, 1'b0);
        chk("rst_error", error_o, 1'b0);

        // ALU path: result at stage 0
        t = cyc;
        dispatch(5'd5);
        step();
        result(0, 64'hAA);
        expect_wb(t + 4, 5'd5, 64'hAA);
        step();
        settle();
        chk("alu_fwd_v", fwd_rd_v_o, 4'b0010);
        chk("alu_fwd_addr", fwd_rd_addr_o[1*AW +: AW], 5'd5);
        chk("alu_fwd_data", fwd_rd_o[1*DW +: DW], 64'hAA);
        step();
        step();
        settle();
        chk("alu_wb_v", wb_v_o, 1'b1);
        step();

        // hazard until a stage-2 result lands
        t = cyc;
        chk_addr_i = {5'd7, 5'd7};
        dispatch(5'd7);
        settle();
        chk("haz_t0", hazard_o, 2'b00);
        step();
        settle();
        chk("haz_t1", hazard_o, 2'b11);
        step();
        settle();
        chk("haz_t2", hazard_o, 2'b11);
        step();
        result(2, 64'h77);
        expect_wb(t + 4, 5'd7, 64'h77);
        settle();
        chk("haz_t3", hazard_o, 2'b11);
        step();
        settle();
        chk("haz_t4", hazard_o, 2'b00);
        chk("haz_fwd_v", fwd_rd_v_o, 4'b1000);
        chk("haz_fwd_data", fwd_rd_o[3*DW +: DW], 64'h77);
        step();

        // kill beats a same-cycle result
        chk_addr_i = {5'd9, 5'd9};
        dispatch(5'd9);
        step();
        settle();
        chk("kill_haz_t1", hazard_o, 2'b11);
        step();
        kill_i[1] = 1'b1;
        result(1, 64'h99);
        settle();
        chk("kill_haz_t2", hazard_o, 2'b11);
        for (int i = 0; i < 4; i++) begin
            step();
            settle();
            chk("kill_fwd_v", fwd_rd_v_o, '0);
            chk("kill_wb_v", wb_v_o, 1'b0);
            chk("kill_haz", hazard_o, 2'b00);
        end
        chk("kill_error", error_o, 1'b0);
        step();

        // x0 destination
        chk_addr_i = '0;
        dispatch(5'd0);
        settle();
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) result(0, 64'h55);
            if (i == 3) result(3, 64'h56);
            settle();
            chk("x0_fwd_v", fwd_rd_v_o, '0);
            chk("x0_haz", hazard_o, 2'b00);
            chk("x0_wb_v", wb_v_o, 1'b0);
        end
        chk("x0_error", error_o, 1'b0);
        step();

        // result delivered directly at the last stage
        t = cyc;
        dispatch(5'd12);
        repeat (4) step();
        result(3, 64'hC3);
        expect_wb(t + 4, 5'd12, 64'hC3);
        settle();
        chk("l_res_wb_v", wb_v_o, 1'b1);
        chk("l_res_wb_data", wb_data_o, 64'hC3);
        chk("l_res_fwd_v", fwd_rd_v_o, '0);
        chk("l_res_error", error_o, 1'b0);
        step();

        // kill at the last stage drops a produced write
        dispatch(5'd13);
        step();
        result(0, 64'h13);
        repeat (3) step();
        kill_i[3] = 1'b1;
        settle();
        chk("l_kill_fwd_v", fwd_rd_v_o, 4'b1000);
        chk("l_kill_wb_v", wb_v_o, 1'b0);
        chk("l_kill_error", error_o, 1'b0);
        step();

        // missing result sets sticky error
        dispatch(5'd3);
        repeat (3) step();
        settle();
        chk("miss_err_t3", error_o, 1'b0);
        step();
        settle();
        chk("miss_err_t4", error_o, 1'b1);
        chk("miss_wb_v", wb_v_o, 1'b0);
        step();
        settle();
        chk("miss_err_t5", error_o, 1'b1);
        step();
        settle();
        chk("miss_err_t6", error_o, 1'b1);

        // reset while a produced write sits in the last stage
        dispatch(5'd4);
        step();
        result(0, 64'h44);
        repeat (3) step();
        reset_i = 1'b1;
        settle();
        chk("mrst_wb_v", wb_v_o, 1'b0);
        step();
        reset_i = 1'b0;
        settle();
        chk("mrst_error", error_o, 1'b0);
        chk("mrst_fwd_v", fwd_rd_v_o, '0);
        chk("mrst_wb_v2", wb_v_o, 1'b0);
        step();
        step();

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bp_be_fwd_pipe.md
# bp_be_fwd_pipe

Result-tracking pipeline that produces the completed-write forwarding vectors (`fwd_rd_v/addr/data`) consumed by the backend bypass network, and the final register-file write. Each dispatched instruction occupies one entry that advances one stage per cycle through `depth_p` stages. Functional units of varying latency deposit results into their stage. The block flags read-after-write hazards on not-yet-produced results and retires writes from the last stage.

## Interface
Parameters:
- `bp_params_p`, `e_bp_default_cfg`: processor config; supplies `reg_addr_width_p` and `dpath_width_p`.
- `depth_p`, 4: number of tracking stages. Must be ≥2.
- `els_p`, 2: number of hazard-check source ports.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `reset_i`  in  1  synchronous, active-high reset.
- `iss_v_i`  in  1  instruction dispatched this cycle.
- `iss_rd_w_v_i`  in  1  dispatched instruction writes rd.
- `iss_rd_addr_i`  in  `reg_addr_width_p`  rd address.
- `res_v_i`  in  `depth_p`  bit k: result for the entry currently in stage k.
- `res_data_i`  in  `depth_p*dpath_width_p`  result data, per stage.
- `kill_i`  in  `depth_p`  bit k: squash the entry currently in stage k.
- `chk_addr_i`  in  `els_p*reg_addr_width_p`  source addresses to hazard-check.
- `hazard_o`  out  `els_p`  source matches a pending write with no result yet.
- `fwd_rd_v_o`  out  `depth_p`  stage k holds a valid, produced rd write. Index 0 is the youngest.
- `fwd_rd_addr_o`  out  `depth_p*reg_addr_width_p`  rd address per stage.
- `fwd_rd_o`  out  `depth_p*dpath_width_p`  rd data per stage.
- `wb_v_o`  out  1  register-file write enable.
- `wb_addr_o`  out  `reg_addr_width_p`  write address.
- `wb_data_o`  out  `dpath_width_p`  write data.
- `error_o`  out  1  sticky: an entry reached the last stage with its write pending and no result.

## Operation
Per-stage state: `v`, `w_v`, `addr`, `data_v`, `data`.

- Dispatch: when `iss_v_i` is high, stage 0 loads `v=1`, `w_v=iss_rd_w_v_i & (iss_rd_addr_i!=0)`, `addr`, and `data_v=0`. Otherwise stage 0 loads `v=0`. Dispatch cannot be killed; the caller gates `iss_v_i`.
- Advance: every cycle, unconditionally, stage k+1 receives stage k. There is no stall input. The entry in stage `depth_p-1` leaves the block.
- Result capture: if `res_v_i[k]` is high and stage k has `v & w_v & !data_v`, the entry arrives in stage k+1 with `data_v=1` and `data=res_data_i[k]`.
  - A result to an invalid entry, a non-writing entry, or an entry whose data is already produced is ignored; the first result wins.
  - `res_v_i[depth_p-1]` feeds writeback directly: `wb_data_o` takes `res_data_i[depth_p-1]` that cycle.
- Kill: if `kill_i[k]` is high, stage k's entry arrives in stage k+1 with `v=0`. Kill beats a same-cycle result.
  - At the last stage, `kill_i[depth_p-1]` suppresses `wb_v_o` combinationally.
- Forwarding: `fwd_rd_v_o[k] = v & w_v & data_v` of stage k. `fwd_rd_addr_o[k]` and `fwd_rd_o[k]` are the stage contents. All three are driven from registers only, with no combinational result bypass.
- Hazard: `hazard_o[j]` is high when some stage k has `v & w_v & !data_v & addr==chk_addr_i[j]`, and `chk_addr_i[j]!=0`. A result arriving that same cycle does not clear the hazard until the next cycle.
- Writeback from the last stage L=`depth_p-1`:
  - `wb_v_o = v & w_v & !kill_i[L] & (data_v | res_v_i[L])`.
  - `wb_addr_o = addr`.
  - `wb_data_o = data_v ? data : res_data_i[L]`.
- Error: if L has `v & w_v & !data_v & !res_v_i[L] & !kill_i[L]`, set `error_o`. It stays set until reset, and `wb_v_o` stays 0 for that entry.
- x0: rd=0 is stored as `w_v=0`. It never forwards, never hazards, and never writes back.

## Timing
- Reset:
  - All `v` and `data_v` are cleared.
  - `error_o=0`.
  - Every output reads 0 on the first cycle after reset, including `fwd_*` and `wb_*`.
  - Reset asserted mid-operation drops all entries, with no writeback that cycle or after.
- An entry dispatched in cycle t occupies stage k during cycle t+1+k.
- A result given at stage k in cycle t+1+k is visible on `fwd_rd_v_o[k+1]` in cycle t+2+k.
- Writeback occurs in cycle t+depth_p.
- `hazard_o` is combinational from the stage registers and `chk_addr_i`.
- `wb_*` is combinational from the last-stage registers, `res_*[L]` and `kill_i[L]`.

## Test plan
- Reset: hold `reset_i` for 2 cycles with `iss_v_i=1` → `fwd_rd_v_o=0`, `hazard_o=0`, `wb_v_o=0`, `error_o=0` on the first cycle after reset.
- ALU path, `depth_p=4`: dispatch rd=5 at t; `res_v_i[0]=1`, data 0xAA at t+1 → at t+2, `fwd_rd_v_o=4'b0010`, addr 5, data 0xAA; at t+4, `wb_v_o=1`, addr 5, data 0xAA.
- Hazard: dispatch rd=7 at t; `chk_addr_i[0]=7`; result at stage 2 at t+3 → `hazard_o[0]=1` for t+1..t+3 and 0 at t+4, when `fwd_rd_v_o[3]=1`.
- Kill vs result: entry rd=9 in stage 1 with `kill_i[1]=1` and `res_v_i[1]=1` in the same cycle → never forwards, `wb_v_o` stays 0, `error_o` stays 0.
- x0: dispatch rd=0 with `iss_rd_w_v_i=1` and results supplied; `chk_addr_i=0` → `fwd_rd_v_o`, `hazard_o` and `wb_v_o` stay 0 throughout.
- Missing result: dispatch rd=3 and supply no result → `error_o=1` at t+4 and stays high until reset; `wb_v_o=0`.
